// File: rtl/hazard_call_injector.sv
// Fetch-stage CALL injector: latches hazard/interrupt requests, waits for a safe
// fetch slot, presents one CALL to the selected vector and blocks until the handler returns.
module hazard_call_injector #(
    parameter int unsigned NUM_SRC     = 4,
    parameter logic [7:0]  CALL_OPCODE = 8'hC4,
    parameter logic [23:0] VECTOR_BASE = 24'h100,
    parameter logic [23:0] VEC_STRIDE  = 24'h10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               inject_en,
    input  logic               inject_ok,
    input  logic               fetch_advance,
    input  logic               flush,
    input  logic               ret_done,
    output logic               sel,
    output logic [31:0]        hazard_call_instruction,
    output logic [NUM_SRC-1:0] ack,
    output logic               busy,
    output logic [2:0]         active_src
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_INJECT,
        S_WAIT_RET
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_ack;
    logic               r_sel;
    logic [31:0]        r_word;
    logic               r_busy;
    logic [2:0]         r_active_src;
    logic [23:0]        r_target;

    logic [2:0]         w_src;
    logic               w_found;
    logic [23:0]        w_target;
    logic [NUM_SRC-1:0] w_ack_onehot;

    // Lowest set pending index wins (bit 0 = highest priority).
    always_comb begin
        w_src   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (r_pending[i] && !w_found) begin
                w_src   = 3'(i);
                w_found = 1'b1;
            end
        end
        w_target = VECTOR_BASE + 24'(w_src) * VEC_STRIDE;
    end

    always_comb begin
        w_ack_onehot = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_ack_onehot[i] = (r_active_src == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_ack        <= '0;
            r_sel        <= 1'b0;
            r_word       <= '0;
            r_busy       <= 1'b0;
            r_active_src <= '0;
            r_target     <= '0;
        end else begin
            // A request coinciding with its own ack is dropped.
            r_pending <= (r_pending | req) & ~r_ack;
            r_ack     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (inject_en && (|r_pending)) begin
                        r_state      <= S_ARM;
                        r_busy       <= 1'b1;
                        r_active_src <= w_src;
                        r_target     <= w_target;
                    end
                end
                S_ARM: begin
                    if (!inject_en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (inject_ok && !flush) begin
                        r_state <= S_INJECT;
                        r_sel   <= 1'b1;
                        r_word  <= {CALL_OPCODE, r_target};
                    end
                end
                S_INJECT: begin
                    if (fetch_advance && !flush) begin
                        r_state <= S_WAIT_RET;
                        r_sel   <= 1'b0;
                        r_word  <= '0;
                        r_ack   <= w_ack_onehot;
                    end
                end
                S_WAIT_RET: begin
                    if (ret_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_sel   <= 1'b0;
                    r_word  <= '0;
                end
            endcase
        end
    end

    assign sel                     = r_sel;
    assign hazard_call_instruction = r_word;
    assign ack                     = r_ack;
    assign busy                    = r_busy;
    assign active_src              = r_active_src;

endmodule

// File: tb/tb_hazard_call_injector.sv
// Directed bench for hazard_call_injector: stimulus pushes expected CALL/ack records,
// a negedge monitor pops and compares them whenever the DUT issues an ack.
module tb_hazard_call_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_w;
    logic        inject_en, inject_ok, fetch_advance, flush, ret_done;

    logic        sel, sel_w;
    logic [31:0] word, word_w;
    logic [3:0]  ack, ack_w;
    logic        busy, busy_w;
    logic [2:0]  src, src_w;

    always #5 clk = ~clk;

    hazard_call_injector u_dut (
        .clk(clk), .rst(rst), .req(req), .inject_en(inject_en), .inject_ok(inject_ok),
        .fetch_advance(fetch_advance), .flush(flush), .ret_done(ret_done),
        .sel(sel), .hazard_call_instruction(word), .ack(ack), .busy(busy), .active_src(src)
    );

    hazard_call_injector #(.VECTOR_BASE(24'hFFFFF8)) u_wrap (
        .clk(clk), .rst(rst), .req(req_w), .inject_en(inject_en), .inject_ok(inject_ok),
        .fetch_advance(fetch_advance), .flush(flush), .ret_done(ret_done),
        .sel(sel_w), .hazard_call_instruction(word_w), .ack(ack_w), .busy(busy_w), .active_src(src_w)
    );

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] word;
        logic [2:0]  src;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] w, input logic [2:0] s);
        exp_t e;
        e.ack  = a;
        e.word = w;
        e.src  = s;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ret();
        ret_done = 1'b1;
        step();
        ret_done = 1'b0;
    endtask

    // Monitor: remember the word shown while sel is high; check it when the ack arrives.
    always @(negedge clk) begin
        if (sel) last_word = word;
        if (ack != 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ack", 32'(ack), 32'(e.ack));
                chk("sb_word", last_word, e.word);
                chk("sb_src", 32'(src), 32'(e.src));
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; req_w = '0; inject_en = 1'b1; inject_ok = 1'b1;
        fetch_advance = 1'b1; flush = 1'b0; ret_done = 1'b0;
        step(); step();
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_word", word, 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_src", 32'(src), 32'h0);
        rst = 1'b0;
        step();

        // 1: single request, sel two edges after the pending latch
        push(4'b0100, 32'hC4000120, 3'd2);
        req = 4'b0100; step(); req = '0;
        chk("t1_sel_e1", 32'(sel), 32'h0);
        step();
        chk("t1_sel_e2", 32'(sel), 32'h0);
        chk("t1_busy_arm", 32'(busy), 32'h1);
        step();
        chk("t1_sel_e3", 32'(sel), 32'h1);
        chk("t1_word", word, 32'hC4000120);
        step();
        chk("t1_ack", 32'(ack), 32'h4);
        chk("t1_sel_drop", 32'(sel), 32'h0);
        chk("t1_word_drop", word, 32'h0);
        step();
        chk("t1_ack_1cyc", 32'(ack), 32'h0);
        pulse_ret();
        chk("t1_idle", 32'(busy), 32'h0);

        // 2: priority and freeze
        push(4'b0010, 32'hC4000110, 3'd1);
        push(4'b1000, 32'hC4000130, 3'd3);
        req = 4'b1010; step(); req = '0;
        step(); step();
        chk("t2a_word", word, 32'hC4000110);
        step(); step(); step();
        chk("t2_waitret_sel", 32'(sel), 32'h0);
        chk("t2_waitret_busy", 32'(busy), 32'h1);
        pulse_ret();
        step(); step();
        chk("t2b_sel", 32'(sel), 32'h1);
        chk("t2b_word", word, 32'hC4000130);
        step(); step();
        pulse_ret();

        // 3: stall and flush
        push(4'b0001, 32'hC4000100, 3'd0);
        req = 4'b0001; step(); req = '0;
        step(); step();
        fetch_advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3a_sel_held", 32'(sel), 32'h1);
            chk("t3a_no_ack", 32'(ack), 32'h0);
        end
        fetch_advance = 1'b1; flush = 1'b1;
        step();
        chk("t3b_sel_flush", 32'(sel), 32'h1);
        chk("t3b_no_ack", 32'(ack), 32'h0);
        chk("t3b_word", word, 32'hC4000100);
        flush = 1'b0;
        step();
        chk("t3c_ack", 32'(ack), 32'h1);
        step();
        pulse_ret();

        // 4: no nesting while waiting for return
        push(4'b0100, 32'hC4000120, 3'd2);
        push(4'b0001, 32'hC4000100, 3'd0);
        req = 4'b0100; step(); req = '0;
        step(); step(); step();
        req = 4'b0001; step(); req = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_blocked", 32'(sel), 32'h0);
        end
        pulse_ret();
        step();
        chk("t4_arm_sel", 32'(sel), 32'h0);
        step();
        chk("t4_sel", 32'(sel), 32'h1);
        chk("t4_word", word, 32'hC4000100);
        step(); step();
        pulse_ret();

        // 5a: hold-off with pending
        inject_en = 1'b0;
        req = 4'b0100; step(); req = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5a_sel", 32'(sel), 32'h0);
            chk("t5a_busy", 32'(busy), 32'h0);
        end
        inject_en = 1'b1; step();
        chk("t5a_arm", 32'(busy), 32'h1);
        inject_en = 1'b0; step();
        chk("t5a_back_idle", 32'(busy), 32'h0);
        chk("t5a_back_sel", 32'(sel), 32'h0);

        // 5b: reset during INJECT abandons the call
        inject_en = 1'b1; fetch_advance = 1'b0;
        step(); step();
        chk("t5b_inject", 32'(sel), 32'h1);
        chk("t5b_src", 32'(src), 32'h2);
        rst = 1'b1; step();
        chk("t5b_sel", 32'(sel), 32'h0);
        chk("t5b_word", word, 32'h0);
        chk("t5b_ack", 32'(ack), 32'h0);
        chk("t5b_busy", 32'(busy), 32'h0);
        chk("t5b_src0", 32'(src), 32'h0);
        rst = 1'b0; fetch_advance = 1'b1;
        step(); step(); step();
        chk("t5b_pending_clr", 32'(busy), 32'h0);

        // 6: 24-bit vector wrap on the second instance
        req_w = 4'b0010; step(); req_w = '0;
        step();
        chk("t6_busy", 32'(busy_w), 32'h1);
        step();
        chk("t6_sel", 32'(sel_w), 32'h1);
        chk("t6_word", word_w, 32'hC4000008);
        chk("t6_src", 32'(src_w), 32'h1);
        step();
        chk("t6_ack", 32'(ack_w), 32'h2);
        pulse_ret();
        step();

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
